// File: rtl/al_serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, FSM state encoding
// and the per-op initial value of the inter-bit carry.
package al_serial_alu_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD    = 2'b00;
    localparam op_t OP_SUB    = 2'b01;
    localparam op_t OP_A_LE_B = 2'b10;
    localparam op_t OP_RSVD   = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic CINIT_ADD    = 1'b0;
    localparam logic CINIT_SUB    = 1'b1;
    localparam logic CINIT_A_LE_B = 1'b1;

    // Subtract-style ops start with carry 1 (the +1 of two's-complement
    // negation); the reserved code behaves as ADD.
    function automatic logic carry_init(input op_t op);
        case (op)
            OP_SUB:    carry_init = CINIT_SUB;
            OP_A_LE_B: carry_init = CINIT_A_LE_B;
            default:   carry_init = CINIT_ADD;
        endcase
    endfunction

endpackage

// File: rtl/al_serial_alu_if.sv
// Request/response bundle of the bit-serial ALU.
// Optional rsp_ovf signal exists only when AL_SERIAL_ALU_OVF_EN is defined.
interface al_serial_alu_if
    import al_serial_alu_pkg::*;
#(
    parameter int W = 32
);
    logic         req_valid;
    logic         req_ready;
    op_t          req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_flag;
`ifdef AL_SERIAL_ALU_OVF_EN
    logic         rsp_ovf;
`endif

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flag
`ifdef AL_SERIAL_ALU_OVF_EN
        , input rsp_ovf
`endif
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flag
`ifdef AL_SERIAL_ALU_OVF_EN
        , output rsp_ovf
`endif
    );

endinterface

// File: rtl/al_serial_alu_slice.sv
// One-bit add/sub/compare slice. SUB computes a + ~b + c, A_LE_B computes
// b + ~a + c; both reduce to the same sum bit and differ only in which
// operand generates the carry when a != b.
module al_serial_alu_slice
    import al_serial_alu_pkg::*;
(
    input  op_t  op,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic c_nxt
);

    // Sum and carry-out for the selected mode; reserved op falls to ADD.
    always_comb begin
        s     = a ^ b ^ c;
        c_nxt = (a == b) ? a : c;
        case (op)
            OP_SUB: begin
                s     = ~(a ^ b ^ c);
                c_nxt = (a != b) ? a : c;
            end
            OP_A_LE_B: begin
                s     = ~(a ^ b ^ c);
                c_nxt = (a != b) ? b : c;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/al_serial_alu.sv
// Bit-serial ALU controller: runs one slice across W-bit operands LSB first,
// W cycles per operation, with valid/ready request and response ports.
// Optional signed-overflow output enabled by AL_SERIAL_ALU_OVF_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready for a request, operands latched on accept
// ST_BUSY | one bit per cycle, counter 0..W-1
// ST_DONE | response valid and held until rsp_ready
module al_serial_alu
    import al_serial_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    al_serial_alu_if.slave bus
);

    localparam int CW = $clog2(W);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    op_t           op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic          c_q;
    logic [W-1:0]  rsp_result_q;
    logic          rsp_flag_q;

    logic          s_bit;
    logic          c_nxt;
    logic          last_bit;
    logic [W-1:0]  res_nxt;

    al_serial_alu_slice u_slice (
        .op    (op_q),
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (c_q),
        .s     (s_bit),
        .c_nxt (c_nxt)
    );

    assign last_bit = (cnt_q == CW'(W - 1));
    assign res_nxt  = (res_q >> 1) | {s_bit, {(W-1){1'b0}}};

    // Handshake outputs; ready is suppressed for as long as reset is held.
    assign bus.req_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid  = (state_q == ST_DONE);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flag   = rsp_flag_q;

    // FSM, operand shifters, carry chain and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            c_q          <= 1'b0;
            rsp_result_q <= '0;
            rsp_flag_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        a_q     <= bus.req_a;
                        b_q     <= bus.req_b;
                        c_q     <= carry_init(bus.req_op);
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_nxt;
                    c_q   <= c_nxt;
                    if (last_bit) begin
                        rsp_result_q <= res_nxt;
                        rsp_flag_q   <= c_nxt;
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef AL_SERIAL_ALU_OVF_EN
    logic ovf_q;

    assign bus.rsp_ovf = ovf_q;

    // Signed overflow = carry into MSB xor carry out; not meaningful for compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_BUSY && last_bit) begin
            ovf_q <= (op_q == OP_A_LE_B) ? 1'b0 : (c_q ^ c_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_al_serial_alu.sv
// Directed self-checking bench for al_serial_alu (W=32).
// Overflow checks are included when AL_SERIAL_ALU_OVF_EN is defined.
module tb_al_serial_alu;
    import al_serial_alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    al_serial_alu_if #(.W(W)) bus ();

    al_serial_alu #(.W(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one operation, wait for the response, optionally hold off
    // rsp_ready and/or pulse req_valid with junk operands while busy.
    // Latency counts clock edges from the acceptance cycle to rsp_valid.
    task automatic run_op(input string tag, input op_t op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_flag,
                          input logic exp_ovf, input bit pulse,
                          input int hold, input int exp_lat);
        int    cycles;
        bit    ok;
        string t;
        t = $sformatf("%s/o%0b", tag, exp_ovf);
        @(negedge clk);
        chk({t, ".ready"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 200) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (pulse && (cycles == 3 || cycles == 10)) begin
                bus.req_valid = 1'b1;
                bus.req_op    = OP_SUB;
                bus.req_a     = 32'hDEADBEEF;
                bus.req_b     = 32'h01234567;
            end else begin
                bus.req_valid = 1'b0;
            end
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({t, ".done"}, ok, 1);
        if (exp_lat > 0) chk({t, ".lat"}, cycles, exp_lat);
        chk({t, ".res"}, bus.rsp_result, exp_res);
        chk({t, ".flag"}, bus.rsp_flag, exp_flag);
`ifdef AL_SERIAL_ALU_OVF_EN
        chk({t, ".ovf"}, bus.rsp_ovf, exp_ovf);
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({t, ".hold_valid"}, bus.rsp_valid, 1);
            chk({t, ".hold_res"}, bus.rsp_result, exp_res);
            chk({t, ".hold_flag"}, bus.rsp_flag, exp_flag);
            chk({t, ".hold_ready"}, bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({t, ".idle_ready"}, bus.req_ready, 1);
        chk({t, ".idle_valid"}, bus.rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = OP_ADD;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst           = 1'b1;

        @(negedge clk);
        chk("rst.req_ready", bus.req_ready, 0);
        chk("rst.rsp_valid", bus.rsp_valid, 0);
        chk("rst.rsp_result", bus.rsp_result, 0);
        chk("rst.rsp_flag", bus.rsp_flag, 0);
`ifdef AL_SERIAL_ALU_OVF_EN
        chk("rst.rsp_ovf", bus.rsp_ovf, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.req_ready", bus.req_ready, 1);

        run_op("add_wrap", OP_ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 0, 33);
        run_op("sub_neg",  OP_SUB,    32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 0, 0);
        run_op("sub_pos",  OP_SUB,    32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, 1'b0, 0, 0);
        run_op("le_eq",    OP_A_LE_B, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b0, 0, 0);
        run_op("le_gt",    OP_A_LE_B, 32'h00000008, 32'h00000007, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0, 0);
        run_op("rsvd_add", OP_RSVD,   32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0, 0, 0);
        run_op("le_max",   OP_A_LE_B, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0, 0);
        run_op("bp_sub",   OP_SUB,    32'h00000100, 32'h00000001, 32'h000000FF, 1'b1, 1'b0, 1'b1, 5, 33);
        run_op("add_min",  OP_ADD,    32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 0, 0);
        run_op("add_ovf",  OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 0, 0);
        run_op("sub_ovf",  OP_SUB,    32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 0, 0);

        // Abort an ADD whose carry is set while bit 10 is pending.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_ADD;
        bus.req_a     = 32'hFFFFFFFF;
        bus.req_b     = 32'h00000001;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst.req_ready", bus.req_ready, 0);
        chk("mid_rst.rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst.rsp_result", bus.rsp_result, 0);
        chk("mid_rst.rsp_flag", bus.rsp_flag, 0);
`ifdef AL_SERIAL_ALU_OVF_EN
        chk("mid_rst.rsp_ovf", bus.rsp_ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst.rsp_valid_after", bus.rsp_valid, 0);

        run_op("after_rst", OP_ADD,   32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 1'b0, 0, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
